// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================
// imm_pkg : shared extender opcodes and constant-encoder states
// Rev 1.0
// ============================================================
package imm_pkg;

   localparam logic [1:0] EOP_SIGN  = 2'b00;
   localparam logic [1:0] EOP_ZERO  = 2'b01;
   localparam logic [1:0] EOP_UPPER = 2'b10;
   localparam logic [1:0] EOP_SHIFT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_OUT1   = 3'd2,
      ST_OUT_HI = 3'd3,
      ST_OUT_LO = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/imm_fit.sv
`default_nettype none
// ============================================================
// imm_fit : does extender mode `mode` reproduce `v`, and with which imm
// Rev 1.0
// ============================================================
module imm_fit
   import imm_pkg::*;
(
   input  logic [31:0] v,
   input  logic [1:0]  mode,
   output logic        fit,
   output logic [15:0] imm
);

   always_comb begin
      fit = 1'b0;
      imm = v[15:0];
      case (mode)
         EOP_SIGN:  fit = (v[31:15] == {17{v[15]}});
         EOP_ZERO:  fit = (v[31:16] == 16'h0000);
         EOP_UPPER: begin
            fit = (v[15:0] == 16'h0000);
            imm = v[31:16];
         end
         EOP_SHIFT: begin
            fit = (v[31:17] == {15{v[17]}}) && (v[1:0] == 2'b00);
            imm = v[17:2];
         end
         default: fit = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/imm_packer.sv
`default_nettype none
// ============================================================
// imm_packer : 32-bit constant -> imm16 + EOp, or lui/ori-style pair
// Rev 1.0
// ============================================================
module imm_packer
   import imm_pkg::*;
#(
   parameter int unsigned ENABLE_SHIFT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] imm,
   output logic [1:0]  EOp,
   output logic        last,
   output logic [15:0] pair_cnt
);

   localparam logic [1:0] LAST_MODE = (ENABLE_SHIFT != 0) ? EOP_SHIFT : EOP_UPPER;

   state_e      state_q, state_d;
   logic [31:0] v_q, v_d;
   logic [1:0]  mode_q, mode_d;
   logic [15:0] imm_q, imm_d;
   logic [1:0]  eop_q, eop_d;
   logic        last_q, last_d;
   logic [15:0] pair_cnt_q, pair_cnt_d;

   logic        fit;
   logic [15:0] fit_imm;

   imm_fit u_fit (
      .v    (v_q),
      .mode (mode_q),
      .fit  (fit),
      .imm  (fit_imm)
   );

   always_comb begin
      state_d    = state_q;
      v_d        = v_q;
      mode_d     = mode_q;
      imm_d      = imm_q;
      eop_d      = eop_q;
      last_d     = last_q;
      pair_cnt_d = pair_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               v_d     = value;
               mode_d  = EOP_SIGN;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (fit) begin
               imm_d   = fit_imm;
               eop_d   = mode_q;
               last_d  = 1'b1;
               state_d = ST_OUT1;
            end else if (mode_q == LAST_MODE) begin
               // nothing fits: emit upper half first, lower half follows
               imm_d   = v_q[31:16];
               eop_d   = EOP_UPPER;
               last_d  = 1'b0;
               state_d = ST_OUT_HI;
            end else begin
               mode_d = mode_q + 2'd1;
            end
         end
         ST_OUT1: begin
            if (out_ready) state_d = ST_IDLE;
         end
         ST_OUT_HI: begin
            if (out_ready) begin
               imm_d   = v_q[15:0];
               eop_d   = EOP_ZERO;
               last_d  = 1'b1;
               state_d = ST_OUT_LO;
               if (pair_cnt_q != 16'hFFFF) pair_cnt_d = pair_cnt_q + 16'd1;
            end
         end
         ST_OUT_LO: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         v_q        <= 32'h0;
         mode_q     <= 2'b00;
         imm_q      <= 16'h0;
         eop_q      <= 2'b00;
         last_q     <= 1'b0;
         pair_cnt_q <= 16'h0;
      end else begin
         state_q    <= state_d;
         v_q        <= v_d;
         mode_q     <= mode_d;
         imm_q      <= imm_d;
         eop_q      <= eop_d;
         last_q     <= last_d;
         pair_cnt_q <= pair_cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUT1) || (state_q == ST_OUT_HI) || (state_q == ST_OUT_LO);
   assign imm       = imm_q;
   assign EOp       = eop_q;
   assign last      = last_q;
   assign pair_cnt  = pair_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_packer.sv
`default_nettype none
// ============================================================
// tb_imm_packer : directed + random checks of imm_packer, both ENABLE_SHIFT settings
// Rev 1.0
// ============================================================
module tb_imm_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] value     [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] imm       [2];
   logic [1:0]  eop       [2];
   logic        last      [2];
   logic [15:0] pair_cnt  [2];

   int          vecs;
   int          errs;
   logic [15:0] exp_pc [2];

   // index 0: shift mode disabled, index 1: shift mode enabled
   imm_packer #(.ENABLE_SHIFT(0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .value(value[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .imm(imm[0]), .EOp(eop[0]), .last(last[0]), .pair_cnt(pair_cnt[0]));

   imm_packer #(.ENABLE_SHIFT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .value(value[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .imm(imm[1]), .EOp(eop[1]), .last(last[1]), .pair_cnt(pair_cnt[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ext(input logic [15:0] i, input logic [1:0] m);
      case (m)
         2'b00:   return {{16{i[15]}}, i};
         2'b01:   return {16'h0000, i};
         2'b10:   return {i, 16'h0000};
         default: return {{14{i[15]}}, i, 2'b00};
      endcase
   endfunction

   // one constant end to end: model, accept, latency, each beat under stall
   task automatic do_txn(input int d, input logic [31:0] val, input int stall);
      logic [1:0]  e_eop  [2];
      logic [15:0] e_imm  [2];
      logic        e_last [2];
      logic [15:0] cand;
      logic [1:0]  mm;
      int nb, lat, n;
      nb = 2; lat = (d == 1) ? 4 : 3;
      e_eop[0] = 2'b10; e_imm[0] = val[31:16]; e_last[0] = 1'b0;
      e_eop[1] = 2'b01; e_imm[1] = val[15:0];  e_last[1] = 1'b1;
      for (int m = 0; m <= ((d == 1) ? 3 : 2); m++) begin
         mm = m[1:0];
         cand = (m == 2) ? val[31:16] : (m == 3) ? val[17:2] : val[15:0];
         if (nb == 2 && ext(cand, mm) == val) begin
            nb = 1; lat = m + 1;
            e_eop[0] = mm; e_imm[0] = cand; e_last[0] = 1'b1;
         end
      end

      @(negedge clk);
      vecs++;
      if (in_ready[d] !== 1'b1) begin
         errs++; $display("FAIL accept_ready d=%0d val=%h: got %b want 1", d, val, in_ready[d]);
      end
      value[d] = val; in_valid[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0; value[d] = $urandom;
      n = 0;
      while (out_valid[d] !== 1'b1 && n < 10) begin
         vecs++;
         if (in_ready[d] !== 1'b0) begin
            errs++; $display("FAIL scan_ready d=%0d val=%h: got %b want 0", d, val, in_ready[d]);
         end
         @(negedge clk);
         n++;
      end
      vecs++;
      if (n != lat) begin
         errs++; $display("FAIL latency d=%0d val=%h: got %0d want %0d", d, val, n, lat);
      end
      if (n >= 10) return;

      for (int b = 0; b < nb; b++) begin
         for (int s = 0; s <= stall; s++) begin
            out_ready[d] = (s == stall);
            vecs++;
            if ({out_valid[d], in_ready[d], eop[d], imm[d], last[d]} !==
                {1'b1, 1'b0, e_eop[b], e_imm[b], e_last[b]}) begin
               errs++;
               $display("FAIL beat%0d d=%0d val=%h: got v=%b r=%b eop=%b imm=%h last=%b want v=1 r=0 eop=%b imm=%h last=%b",
                        b, d, val, out_valid[d], in_ready[d], eop[d], imm[d], last[d], e_eop[b], e_imm[b], e_last[b]);
            end
            @(negedge clk);
         end
         out_ready[d] = 1'b0;
         if (nb == 2 && b == 0 && exp_pc[d] != 16'hFFFF) exp_pc[d] = exp_pc[d] + 16'd1;
      end
      vecs++;
      if ({out_valid[d], in_ready[d], pair_cnt[d]} !== {1'b0, 1'b1, exp_pc[d]}) begin
         errs++;
         $display("FAIL done d=%0d val=%h: got v=%b r=%b pc=%h want v=0 r=1 pc=%h",
                  d, val, out_valid[d], in_ready[d], pair_cnt[d], exp_pc[d]);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         vecs++;
         if ({in_ready[d], out_valid[d], imm[d], eop[d], last[d], pair_cnt[d]} !==
             {1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0}) begin
            errs++;
            $display("FAIL %s d=%0d: got r=%b v=%b imm=%h eop=%b last=%b pc=%h want r=1 v=0 zeros",
                     tag, d, in_ready[d], out_valid[d], imm[d], eop[d], last[d], pair_cnt[d]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; value[d] = 32'h0; out_ready[d] = 1'b0; exp_pc[d] = 16'h0;
      end
      repeat (3) @(negedge clk);
      check_reset_state("reset_state");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sign_zero();
      do_txn(1, 32'hFFFF8000, 0);
      do_txn(0, 32'hFFFF8000, 0);
      do_txn(1, 32'h0000ABCD, 1);
      do_txn(1, 32'h00000000, 0);
      do_txn(1, 32'h00007FFF, 0);
   endtask

   task automatic test_upper_shift();
      do_txn(1, 32'h12340000, 0);
      do_txn(1, 32'hFFFE0004, 2);
      do_txn(0, 32'hFFFE0004, 0);
      do_txn(1, 32'h0001FFFC, 0);
      do_txn(1, 32'h00020000, 0);
   endtask

   task automatic test_pair_backpressure();
      do_txn(1, 32'h12345678, 3);
      do_txn(0, 32'h12345678, 3);
      do_txn(1, 32'h80000001, 0);
   endtask

   task automatic test_reset_mid();
      // reset while scanning
      @(negedge clk);
      value[1] = 32'h12345678; in_valid[1] = 1'b1;
      @(negedge clk);
      in_valid[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_pc[0] = 16'h0; exp_pc[1] = 16'h0;
      check_reset_state("reset_mid_scan");
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(1, 32'h00000001, 0);
      // reset while the upper beat is stalled
      do_txn(0, 32'h12345678, 0);
      @(negedge clk);
      value[0] = 32'h12345678; in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      vecs++;
      if (out_valid[0] !== 1'b1) begin
         errs++; $display("FAIL pre_reset_hi: got out_valid=%b want 1", out_valid[0]);
      end
      rst_n = 1'b0;
      #1;
      exp_pc[0] = 16'h0; exp_pc[1] = 16'h0;
      check_reset_state("reset_mid_pair");
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(0, 32'h00000001, 0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int i = 0; i < 60; i++) begin
         r = $urandom;
         case ($urandom_range(0, 4))
            0: r = {{16{r[15]}}, r[15:0]};
            1: r = {16'h0, r[15:0]};
            2: r = {r[31:16], 16'h0};
            3: r = {{14{r[17]}}, r[17:2], 2'b00};
            default: ;
         endcase
         do_txn(i % 2, r, $urandom_range(0, 2));
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      force dut_s.pair_cnt_q = 16'hFFFE;
      @(negedge clk);
      @(negedge clk);
      release dut_s.pair_cnt_q;
      exp_pc[1] = 16'hFFFE;
      do_txn(1, 32'hDEADBEEF, 0);
      do_txn(1, 32'hCAFEF00D, 1);
      vecs++;
      if (pair_cnt[1] !== 16'hFFFF) begin
         errs++; $display("FAIL saturate: got pc=%h want ffff", pair_cnt[1]);
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_sign_zero();
      test_upper_shift();
      test_pair_backpressure();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire
